ce_pixel_pacer: RTL and testbench



---
 rtl/ce_pkg.sv | 23 ++
 rtl/ce_sync_fifo.sv | 67 ++++++
 rtl/ce_pixel_pacer.sv | 90 +++++++++
 tb/tb_ce_pixel_pacer.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ce_pkg.sv
// Shared constants and helpers for the clock-enable pixel pacer.
//   DW_DEF / DEPTH_DEF / UCW_DEF : default data width, FIFO depth, underrun counter width
//   clog2()                      : ceiling log2 for constant width calculations
//   PW_DEF / LW_DEF              : default pointer and level widths
package ce_pkg;

  localparam int unsigned DW_DEF    = 16;
  localparam int unsigned DEPTH_DEF = 8;
  localparam int unsigned UCW_DEF   = 8;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  localparam int unsigned PW_DEF = clog2(DEPTH_DEF);
  localparam int unsigned LW_DEF = PW_DEF + 1;

endpackage

// File: rtl/ce_sync_fifo.sv
// Single-clock FIFO: register array, wrapping pointers and an occupancy counter.
//   iClk, iRst     : clock, asynchronous active-low reset
//   i_push, i_pop  : write / read requests (ignored when full / empty)
//   i_flush        : synchronous empty; suppresses push and pop that cycle
//   i_data         : write data
//   o_rdata        : word at the read pointer (combinational)
//   o_level        : occupancy 0..DEPTH
//   o_full/o_empty : status flags
module ce_sync_fifo
  import ce_pkg::*;
#(
  parameter  int unsigned DW    = DW_DEF,
  parameter  int unsigned DEPTH = DEPTH_DEF,
  localparam int unsigned PW    = clog2(DEPTH),
  localparam int unsigned LW    = PW + 1
) (
  input  logic          iClk,
  input  logic          iRst,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic          i_flush,
  input  logic [DW-1:0] i_data,
  output logic [DW-1:0] o_rdata,
  output logic [LW-1:0] o_level,
  output logic          o_full,
  output logic          o_empty
);

  logic [DW-1:0] r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [LW-1:0] r_level;
  logic          w_push;
  logic          w_pop;

  assign o_full  = (r_level == LW'(DEPTH));
  assign o_empty = (r_level == '0);
  assign w_push  = i_push && !o_full  && !i_flush;
  assign w_pop   = i_pop  && !o_empty && !i_flush;
  assign o_rdata = r_mem[r_rd_ptr];
  assign o_level = r_level;

  always_ff @(posedge iClk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/ce_pixel_pacer.sv
// Releases one buffered pixel per clock-enable pulse and tracks underruns.
//   iClk, iRst            : clock, asynchronous active-low reset
//   iEnable               : pacing pulse; pops one word if available
//   iFlush                : synchronous FIFO flush
//   iValid/iData/oReady   : upstream handshake (words offered while !oReady are dropped)
//   oValid/oData          : one-cycle release strobe, data held between strobes
//   oLevel                : FIFO occupancy
//   oUnderrun/oUnderrunCnt: sticky flag and saturating count of empty-FIFO pulses
//   iClrErr               : clears the underrun flag and counter (wins over a new underrun)
module ce_pixel_pacer
  import ce_pkg::*;
#(
  parameter  int unsigned DW    = DW_DEF,
  parameter  int unsigned DEPTH = DEPTH_DEF,
  parameter  int unsigned UCW   = UCW_DEF,
  localparam int unsigned LW    = clog2(DEPTH) + 1
) (
  input  logic           iClk,
  input  logic           iRst,
  input  logic           iEnable,
  input  logic           iFlush,
  input  logic           iValid,
  input  logic [DW-1:0]  iData,
  output logic           oReady,
  output logic           oValid,
  output logic [DW-1:0]  oData,
  output logic [LW-1:0]  oLevel,
  output logic           oUnderrun,
  output logic [UCW-1:0] oUnderrunCnt,
  input  logic           iClrErr
);

  logic [DW-1:0]  w_rdata;
  logic           w_full;
  logic           w_empty;
  logic           w_push;
  logic           w_pop;
  logic           w_underrun;
  logic           r_valid;
  logic [DW-1:0]  r_data;
  logic           r_underrun;
  logic [UCW-1:0] r_ucnt;

  // Full blocks a push even when a pop happens the same cycle: no fall-through.
  assign oReady     = !w_full && !iFlush;
  assign w_push     = iValid && oReady;
  assign w_pop      = iEnable && !w_empty && !iFlush;
  assign w_underrun = iEnable && w_empty && !iFlush;

  ce_sync_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .iClk    (iClk),
    .iRst    (iRst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (iFlush),
    .i_data  (iData),
    .o_rdata (w_rdata),
    .o_level (oLevel),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      r_valid    <= 1'b0;
      r_data     <= '0;
      r_underrun <= 1'b0;
      r_ucnt     <= '0;
    end else begin
      r_valid <= w_pop;
      if (w_pop) r_data <= w_rdata;
      if (iClrErr) begin
        r_underrun <= 1'b0;
        r_ucnt     <= '0;
      end else if (w_underrun) begin
        r_underrun <= 1'b1;
        if (r_ucnt != '1) r_ucnt <= r_ucnt + UCW'(1);
      end
    end
  end

  assign oValid       = r_valid;
  assign oData        = r_data;
  assign oUnderrun    = r_underrun;
  assign oUnderrunCnt = r_ucnt;

endmodule

// File: tb/tb_ce_pixel_pacer.sv
module tb_ce_pixel_pacer;

  logic        iClk = 1'b0;
  logic        iRst = 1'b0;
  logic        iEnable = 1'b0;
  logic        iFlush = 1'b0;
  logic        iValid = 1'b0;
  logic [15:0] iData = '0;
  logic        iClrErr = 1'b0;
  logic        oReady;
  logic        oValid;
  logic [15:0] oData;
  logic [3:0]  oLevel;
  logic        oUnderrun;
  logic [7:0]  oUnderrunCnt;

  int checks = 0;
  int failures = 0;

  always #5 iClk = ~iClk;

  ce_pixel_pacer #(.DW(16), .DEPTH(8), .UCW(8)) dut (
    .iClk         (iClk),
    .iRst         (iRst),
    .iEnable      (iEnable),
    .iFlush       (iFlush),
    .iValid       (iValid),
    .iData        (iData),
    .oReady       (oReady),
    .oValid       (oValid),
    .oData        (oData),
    .oLevel       (oLevel),
    .oUnderrun    (oUnderrun),
    .oUnderrunCnt (oUnderrunCnt),
    .iClrErr      (iClrErr)
  );

  typedef struct {
    logic        en, fl, v;
    logic [15:0] d;
    logic        clr;
    logic        ev;
    logic [15:0] ed;
    logic [3:0]  el;
    logic        er, eu;
    logic [7:0]  ec;
  } vec_t;

  vec_t tbl[16];

  function automatic vec_t mk(logic en, logic fl, logic v, logic [15:0] d, logic clr,
                              logic ev, logic [15:0] ed, logic [3:0] el, logic er,
                              logic eu, logic [7:0] ec);
    vec_t r;
    r.en = en; r.fl = fl; r.v = v; r.d = d; r.clr = clr;
    r.ev = ev; r.ed = ed; r.el = el; r.er = er; r.eu = eu; r.ec = ec;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  task automatic idle_inputs();
    iEnable = 1'b0; iFlush = 1'b0; iValid = 1'b0; iData = '0; iClrErr = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    iRst = 1'b0;
    tick();
    iRst = 1'b1;
    tick();
  endtask

  task automatic push(input logic [15:0] d);
    iValid = 1'b1; iData = d;
    tick();
    iValid = 1'b0;
  endtask

  task automatic pulse_en();
    iEnable = 1'b1;
    tick();
    iEnable = 1'b0;
  endtask

  initial begin
    // {en, fl, v, d, clr} -> {valid, data, level, ready, underrun, count}
    tbl[0]  = mk(1,0,0,16'h0000,0, 0,16'h0000,0,1,1,1);
    tbl[1]  = mk(0,0,0,16'h0000,0, 0,16'h0000,0,1,1,1);
    tbl[2]  = mk(1,0,0,16'h0000,0, 0,16'h0000,0,1,1,2);
    tbl[3]  = mk(1,0,0,16'h0000,0, 0,16'h0000,0,1,1,3);
    tbl[4]  = mk(1,0,0,16'h0000,1, 0,16'h0000,0,1,0,0);
    tbl[5]  = mk(0,0,1,16'h0001,0, 0,16'h0000,1,1,0,0);
    tbl[6]  = mk(1,0,1,16'h0002,0, 1,16'h0001,1,1,0,0);
    tbl[7]  = mk(0,0,0,16'h0000,0, 0,16'h0001,1,1,0,0);
    tbl[8]  = mk(0,0,1,16'h0003,0, 0,16'h0001,2,1,0,0);
    tbl[9]  = mk(1,0,1,16'h0004,0, 1,16'h0002,2,1,0,0);
    tbl[10] = mk(1,0,0,16'h0000,0, 1,16'h0003,1,1,0,0);
    tbl[11] = mk(1,1,1,16'hDEAD,0, 0,16'h0003,0,1,0,0);
    tbl[12] = mk(1,0,0,16'h0000,0, 0,16'h0003,0,1,1,1);
    tbl[13] = mk(1,0,1,16'h0005,0, 0,16'h0003,1,1,1,2);
    tbl[14] = mk(1,0,0,16'h0000,0, 1,16'h0005,0,1,1,2);
    tbl[15] = mk(0,0,0,16'h0000,1, 0,16'h0005,0,1,0,0);

    do_reset();
    chk("rst_valid", oValid, 0);
    chk("rst_data", oData, 0);
    chk("rst_level", oLevel, 0);
    chk("rst_ready", oReady, 1);
    chk("rst_unf", oUnderrun, 0);
    chk("rst_cnt", oUnderrunCnt, 0);

    for (int i = 0; i < 16; i++) begin
      iEnable = tbl[i].en; iFlush = tbl[i].fl; iValid = tbl[i].v;
      iData = tbl[i].d; iClrErr = tbl[i].clr;
      tick();
      idle_inputs();
      #1;
      chk($sformatf("v%0d_valid", i), oValid, tbl[i].ev);
      chk($sformatf("v%0d_data", i), oData, tbl[i].ed);
      chk($sformatf("v%0d_level", i), oLevel, tbl[i].el);
      chk($sformatf("v%0d_ready", i), oReady, tbl[i].er);
      chk($sformatf("v%0d_unf", i), oUnderrun, tbl[i].eu);
      chk($sformatf("v%0d_cnt", i), oUnderrunCnt, tbl[i].ec);
    end

    // Divide-by-8 pacing with no data.
    do_reset();
    for (int k = 0; k < 3; k++) begin
      pulse_en();
      chk("div8_nodata_valid", oValid, 0);
      repeat (7) tick();
    end
    chk("div8_nodata_cnt", oUnderrunCnt, 3);
    chk("div8_nodata_unf", oUnderrun, 1);

    // Five back-to-back pushes released one per divide-by-8 pulse.
    do_reset();
    for (int k = 1; k <= 5; k++) push(16'(k));
    chk("paced_peak_level", oLevel, 5);
    for (int k = 1; k <= 5; k++) begin
      pulse_en();
      chk("paced_strobe", oValid, 1);
      chk("paced_data", oData, 16'(k));
      for (int g = 0; g < 7; g++) begin
        tick();
        chk("paced_gap_valid", oValid, 0);
        chk("paced_gap_hold", oData, 16'(k));
      end
    end
    chk("paced_end_level", oLevel, 0);
    chk("paced_no_unf", oUnderrun, 0);

    // Overfill: words 9 and 10 are dropped.
    do_reset();
    for (int k = 1; k <= 10; k++) begin
      push(16'h0100 + 16'(k));
      if (k == 8) chk("ovf_ready_after8", oReady, 0);
    end
    chk("ovf_level", oLevel, 8);
    for (int k = 1; k <= 8; k++) begin
      pulse_en();
      chk("ovf_pop_data", oData, 16'h0100 + 16'(k));
      chk("ovf_pop_valid", oValid, 1);
    end
    chk("ovf_empty", oLevel, 0);
    pulse_en();
    chk("ovf_tail_valid", oValid, 0);
    chk("ovf_tail_unf", oUnderrunCnt, 1);

    // Full FIFO with same-cycle enable and valid.
    do_reset();
    for (int k = 1; k <= 8; k++) push(16'h0200 + 16'(k));
    iEnable = 1'b1; iValid = 1'b1; iData = 16'hBEEF;
    #1;
    chk("full_pop_ready_same_cycle", oReady, 0);
    tick();
    idle_inputs();
    #1;
    chk("full_pop_level", oLevel, 7);
    chk("full_pop_ready_next", oReady, 1);
    chk("full_pop_data", oData, 16'h0201);
    for (int k = 2; k <= 8; k++) begin
      pulse_en();
      chk("full_drain_data", oData, 16'h0200 + 16'(k));
    end
    chk("full_drain_level", oLevel, 0);

    // Flush at level 4 coinciding with an enable.
    do_reset();
    for (int k = 1; k <= 4; k++) push(16'h0300 + 16'(k));
    pulse_en();
    chk("flush_pre_data", oData, 16'h0301);
    chk("flush_pre_level", oLevel, 3);
    push(16'h0305);
    iFlush = 1'b1; iEnable = 1'b1;
    #1;
    chk("flush_ready_low", oReady, 0);
    tick();
    idle_inputs();
    #1;
    chk("flush_valid", oValid, 0);
    chk("flush_level", oLevel, 0);
    chk("flush_data_held", oData, 16'h0301);
    chk("flush_cnt", oUnderrunCnt, 0);
    pulse_en();
    chk("flush_then_unf", oUnderrunCnt, 1);

    // Saturation and clear priority.
    do_reset();
    iEnable = 1'b1;
    repeat (300) tick();
    iEnable = 1'b0;
    #1;
    chk("sat_cnt", oUnderrunCnt, 8'hFF);
    chk("sat_unf", oUnderrun, 1);
    iEnable = 1'b1; iClrErr = 1'b1;
    tick();
    idle_inputs();
    #1;
    chk("clr_prio_cnt", oUnderrunCnt, 0);
    chk("clr_prio_unf", oUnderrun, 0);

    // Asynchronous reset mid-stream.
    push(16'h0A0A);
    push(16'h0B0B);
    iEnable = 1'b1; iValid = 1'b1; iData = 16'h0C0C;
    tick();
    chk("arst_pre_valid", oValid, 1);
    #2;
    iRst = 1'b0;
    #1;
    chk("arst_valid", oValid, 0);
    chk("arst_data", oData, 0);
    chk("arst_level", oLevel, 0);
    chk("arst_unf", oUnderrun, 0);
    chk("arst_cnt", oUnderrunCnt, 0);
    idle_inputs();
    tick();
    iRst = 1'b1;
    tick();
    chk("arst_release_ready", oReady, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
